// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit direction counters, mispredict detection and perf counters
module branch_predictor #(
  parameter int PC_WIDTH    = 32,
  parameter int INDEX_WIDTH = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [PC_WIDTH-1:0]    PCF_i,
  output logic                   PredTakenF_o,
  output logic [PC_WIDTH-1:0]    PredTargetF_o,
  input  logic                   UpdateE_i,
  input  logic                   IsJumpE_i,
  input  logic [PC_WIDTH-1:0]    PCE_i,
  input  logic                   TakenE_i,
  input  logic [PC_WIDTH-1:0]    TargetE_i,
  input  logic                   PredTakenE_i,
  input  logic [PC_WIDTH-1:0]    PredTargetE_i,
  output logic                   MispredictE_o,
  output logic [PC_WIDTH-1:0]    RecoverPCE_o,
  output logic [COUNT_WIDTH-1:0] BranchCount_o,
  output logic [COUNT_WIDTH-1:0] MissCount_o
);
  localparam int TAG_WIDTH = PC_WIDTH - INDEX_WIDTH - 2;
  localparam int ENTRIES   = 1 << INDEX_WIDTH;
  logic [ENTRIES-1:0]     valid;
  logic [TAG_WIDTH-1:0]   tagMem    [ENTRIES];
  logic [PC_WIDTH-1:0]    targetMem [ENTRIES];
  logic [1:0]             ctrMem    [ENTRIES];
  logic [ENTRIES-1:0]     jumpMem;
  logic [INDEX_WIDTH-1:0] idxF, idxE;
  logic [TAG_WIDTH-1:0]   tagF, tagE;
  logic                   hitF, hitE;
  logic [1:0]             ctrE, ctrNext;
  logic [COUNT_WIDTH-1:0] branchCount, missCount;
  assign idxF = PCF_i[INDEX_WIDTH+1:2];
  assign tagF = PCF_i[PC_WIDTH-1:INDEX_WIDTH+2];
  assign idxE = PCE_i[INDEX_WIDTH+1:2];
  assign tagE = PCE_i[PC_WIDTH-1:INDEX_WIDTH+2];
  assign hitF = valid[idxF] && tagMem[idxF] == tagF;
  assign hitE = valid[idxE] && tagMem[idxE] == tagE;
  assign PredTakenF_o  = hitF && (jumpMem[idxF] || ctrMem[idxF][1]);
  assign PredTargetF_o = PredTakenF_o ? targetMem[idxF] : PCF_i + PC_WIDTH'(4);
  assign MispredictE_o = UpdateE_i && ((PredTakenE_i != TakenE_i) || (TakenE_i && PredTargetE_i != TargetE_i));
  assign RecoverPCE_o  = TakenE_i ? TargetE_i : PCE_i + PC_WIDTH'(4);
  assign BranchCount_o = branchCount;
  assign MissCount_o   = missCount;
  always_comb begin
    ctrE    = ctrMem[idxE];
    ctrNext = IsJumpE_i ? 2'b11
            : TakenE_i  ? (ctrE == 2'b11 ? 2'b11 : ctrE + 2'b01)
            :             (ctrE == 2'b00 ? 2'b00 : ctrE - 2'b01);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid       <= '0;
      branchCount <= '0;
      missCount   <= '0;
    end else if (UpdateE_i) begin
      branchCount <= branchCount + COUNT_WIDTH'(~&branchCount);
      missCount   <= missCount + COUNT_WIDTH'(MispredictE_o && ~&missCount);
      if (hitE) begin
        ctrMem[idxE] <= ctrNext;
        if (IsJumpE_i) jumpMem[idxE] <= 1'b1;
        if (TakenE_i) targetMem[idxE] <= TargetE_i;
      end else if (TakenE_i) begin
        valid[idxE]     <= 1'b1;
        tagMem[idxE]    <= tagE;
        targetMem[idxE] <= TargetE_i;
        jumpMem[idxE]   <= IsJumpE_i;
        ctrMem[idxE]    <= IsJumpE_i ? 2'b11 : 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench for branch_predictor (INDEX_WIDTH=4, COUNT_WIDTH=2)
module tb_branch_predictor;
  localparam int PW = 32;
  localparam int IW = 4;
  localparam int CW = 2;
  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [PW-1:0] PCF_i = '0;
  logic          PredTakenF_o;
  logic [PW-1:0] PredTargetF_o;
  logic          UpdateE_i = 1'b0;
  logic          IsJumpE_i = 1'b0;
  logic [PW-1:0] PCE_i = '0;
  logic          TakenE_i = 1'b0;
  logic [PW-1:0] TargetE_i = '0;
  logic          PredTakenE_i = 1'b0;
  logic [PW-1:0] PredTargetE_i = '0;
  logic          MispredictE_o;
  logic [PW-1:0] RecoverPCE_o;
  logic [CW-1:0] BranchCount_o;
  logic [CW-1:0] MissCount_o;

  always #5 clk_i = ~clk_i;

  branch_predictor #(.PC_WIDTH(PW), .INDEX_WIDTH(IW), .COUNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .PCF_i(PCF_i),
    .PredTakenF_o(PredTakenF_o), .PredTargetF_o(PredTargetF_o),
    .UpdateE_i(UpdateE_i), .IsJumpE_i(IsJumpE_i), .PCE_i(PCE_i),
    .TakenE_i(TakenE_i), .TargetE_i(TargetE_i),
    .PredTakenE_i(PredTakenE_i), .PredTargetE_i(PredTargetE_i),
    .MispredictE_o(MispredictE_o), .RecoverPCE_o(RecoverPCE_o),
    .BranchCount_o(BranchCount_o), .MissCount_o(MissCount_o)
  );

  typedef struct {
    logic rst, upd, jmp, tkn, ptkn;
    logic [PW-1:0] pce, tgt, ptgt, pcf;
  } stim_t;
  typedef struct {
    logic pt;
    logic [PW-1:0] ptg;
    logic mis;
    logic [PW-1:0] rec;
    logic [CW-1:0] bc, mc;
  } exp_t;

  stim_t stims[$];
  exp_t  exps[$];
  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;

  function automatic stim_t st(input logic r, input logic u, input logic j, input logic [PW-1:0] pce,
                               input logic tkn, input logic [PW-1:0] tgt, input logic ptkn,
                               input logic [PW-1:0] ptgt, input logic [PW-1:0] pcf);
    stim_t s;
    s.rst = r; s.upd = u; s.jmp = j; s.pce = pce; s.tkn = tkn;
    s.tgt = tgt; s.ptkn = ptkn; s.ptgt = ptgt; s.pcf = pcf;
    return s;
  endfunction

  function automatic exp_t ex(input logic pt, input logic [PW-1:0] ptg, input logic mis,
                              input logic [PW-1:0] rec, input logic [CW-1:0] bc, input logic [CW-1:0] mc);
    exp_t e;
    e.pt = pt; e.ptg = ptg; e.mis = mis; e.rec = rec; e.bc = bc; e.mc = mc;
    return e;
  endfunction

  task automatic add(input stim_t s, input exp_t e);
    stims.push_back(s);
    exps.push_back(e);
  endtask

  task automatic idle(input logic [PW-1:0] pcf, input exp_t e);
    add(st(0, 0, 0, '0, 0, '0, 0, '0, pcf), e);
  endtask

  task automatic drive(input stim_t s, input exp_t e);
    @(negedge clk_i);
    rst_i = s.rst; UpdateE_i = s.upd; IsJumpE_i = s.jmp; PCE_i = s.pce; TakenE_i = s.tkn;
    TargetE_i = s.tgt; PredTakenE_i = s.ptkn; PredTargetE_i = s.ptgt; PCF_i = s.pcf;
    sb.push_back(e);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; UpdateE_i = 1'b0; IsJumpE_i = 1'b0; TakenE_i = 1'b0; PredTakenE_i = 1'b0;
    repeat (2) @(posedge clk_i);
  endtask

  task automatic test_reset();
    exp_t e;
    int i = 0;
    add(st(1, 1, 0, 32'h100, 1, 32'h080, 0, 32'h104, 32'h100), ex(0, 32'h104, 1, 32'h080, 0, 0));
    idle(32'h100, ex(0, 32'h104, 0, '0, 0, 0));
    while (stims.size() > 0) begin
      drive(stims.pop_front(), exps.pop_front());
      e = sb.pop_front();
      checks += 5;
      if (PredTakenF_o !== e.pt) begin failures++; $display("FAIL reset[%0d] predTaken got %0b want %0b", i, PredTakenF_o, e.pt); end
      if (PredTargetF_o !== e.ptg) begin failures++; $display("FAIL reset[%0d] predTarget got %h want %h", i, PredTargetF_o, e.ptg); end
      if (MispredictE_o !== e.mis) begin failures++; $display("FAIL reset[%0d] mispredict got %0b want %0b", i, MispredictE_o, e.mis); end
      if (BranchCount_o !== e.bc) begin failures++; $display("FAIL reset[%0d] branchCount got %0d want %0d", i, BranchCount_o, e.bc); end
      if (MissCount_o !== e.mc) begin failures++; $display("FAIL reset[%0d] missCount got %0d want %0d", i, MissCount_o, e.mc); end
      if (UpdateE_i) begin
        checks++;
        if (RecoverPCE_o !== e.rec) begin failures++; $display("FAIL reset[%0d] recoverPC got %h want %h", i, RecoverPCE_o, e.rec); end
      end
      i++;
    end
  endtask

  task automatic test_allocate();
    exp_t e;
    int i = 0;
    add(st(0, 1, 0, 32'h100, 1, 32'h080, 0, 32'h104, 32'h100), ex(0, 32'h104, 1, 32'h080, 0, 0));
    idle(32'h100, ex(1, 32'h080, 0, '0, 1, 1));
    while (stims.size() > 0) begin
      drive(stims.pop_front(), exps.pop_front());
      e = sb.pop_front();
      checks += 5;
      if (PredTakenF_o !== e.pt) begin failures++; $display("FAIL alloc[%0d] predTaken got %0b want %0b", i, PredTakenF_o, e.pt); end
      if (PredTargetF_o !== e.ptg) begin failures++; $display("FAIL alloc[%0d] predTarget got %h want %h", i, PredTargetF_o, e.ptg); end
      if (MispredictE_o !== e.mis) begin failures++; $display("FAIL alloc[%0d] mispredict got %0b want %0b", i, MispredictE_o, e.mis); end
      if (BranchCount_o !== e.bc) begin failures++; $display("FAIL alloc[%0d] branchCount got %0d want %0d", i, BranchCount_o, e.bc); end
      if (MissCount_o !== e.mc) begin failures++; $display("FAIL alloc[%0d] missCount got %0d want %0d", i, MissCount_o, e.mc); end
      if (UpdateE_i) begin
        checks++;
        if (RecoverPCE_o !== e.rec) begin failures++; $display("FAIL alloc[%0d] recoverPC got %h want %h", i, RecoverPCE_o, e.rec); end
      end
      i++;
    end
  endtask

  task automatic test_counter_walk();
    exp_t e;
    int i = 0;
    add(st(0, 1, 0, 32'h100, 0, 32'h080, 1, 32'h080, 32'h100), ex(1, 32'h080, 1, 32'h104, 1, 1));
    idle(32'h100, ex(0, 32'h104, 0, '0, 2, 2));
    add(st(0, 1, 0, 32'h100, 0, 32'h080, 0, 32'h104, 32'h100), ex(0, 32'h104, 0, 32'h104, 2, 2));
    add(st(0, 1, 0, 32'h100, 1, 32'h080, 0, 32'h104, 32'h100), ex(0, 32'h104, 1, 32'h080, 3, 2));
    add(st(0, 1, 0, 32'h100, 1, 32'h080, 0, 32'h104, 32'h100), ex(0, 32'h104, 1, 32'h080, 3, 3));
    idle(32'h100, ex(1, 32'h080, 0, '0, 3, 3));
    add(st(0, 1, 0, 32'h100, 1, 32'h090, 1, 32'h080, 32'h100), ex(1, 32'h080, 1, 32'h090, 3, 3));
    add(st(0, 1, 0, 32'h100, 1, 32'h090, 1, 32'h090, 32'h100), ex(1, 32'h090, 0, 32'h090, 3, 3));
    while (stims.size() > 0) begin
      drive(stims.pop_front(), exps.pop_front());
      e = sb.pop_front();
      checks += 5;
      if (PredTakenF_o !== e.pt) begin failures++; $display("FAIL walk[%0d] predTaken got %0b want %0b", i, PredTakenF_o, e.pt); end
      if (PredTargetF_o !== e.ptg) begin failures++; $display("FAIL walk[%0d] predTarget got %h want %h", i, PredTargetF_o, e.ptg); end
      if (MispredictE_o !== e.mis) begin failures++; $display("FAIL walk[%0d] mispredict got %0b want %0b", i, MispredictE_o, e.mis); end
      if (BranchCount_o !== e.bc) begin failures++; $display("FAIL walk[%0d] branchCount got %0d want %0d", i, BranchCount_o, e.bc); end
      if (MissCount_o !== e.mc) begin failures++; $display("FAIL walk[%0d] missCount got %0d want %0d", i, MissCount_o, e.mc); end
      if (UpdateE_i) begin
        checks++;
        if (RecoverPCE_o !== e.rec) begin failures++; $display("FAIL walk[%0d] recoverPC got %h want %h", i, RecoverPCE_o, e.rec); end
      end
      i++;
    end
  endtask

  task automatic test_alias();
    exp_t e;
    int i = 0;
    idle(32'h140, ex(0, 32'h144, 0, '0, 3, 3));
    idle(32'h100, ex(1, 32'h090, 0, '0, 3, 3));
    add(st(0, 1, 0, 32'h140, 1, 32'h200, 0, 32'h144, 32'h140), ex(0, 32'h144, 1, 32'h200, 3, 3));
    idle(32'h140, ex(1, 32'h200, 0, '0, 3, 3));
    idle(32'h100, ex(0, 32'h104, 0, '0, 3, 3));
    idle(32'h104, ex(0, 32'h108, 0, '0, 3, 3));
    idle(32'h142, ex(1, 32'h200, 0, '0, 3, 3));
    while (stims.size() > 0) begin
      drive(stims.pop_front(), exps.pop_front());
      e = sb.pop_front();
      checks += 5;
      if (PredTakenF_o !== e.pt) begin failures++; $display("FAIL alias[%0d] predTaken got %0b want %0b", i, PredTakenF_o, e.pt); end
      if (PredTargetF_o !== e.ptg) begin failures++; $display("FAIL alias[%0d] predTarget got %h want %h", i, PredTargetF_o, e.ptg); end
      if (MispredictE_o !== e.mis) begin failures++; $display("FAIL alias[%0d] mispredict got %0b want %0b", i, MispredictE_o, e.mis); end
      if (BranchCount_o !== e.bc) begin failures++; $display("FAIL alias[%0d] branchCount got %0d want %0d", i, BranchCount_o, e.bc); end
      if (MissCount_o !== e.mc) begin failures++; $display("FAIL alias[%0d] missCount got %0d want %0d", i, MissCount_o, e.mc); end
      if (UpdateE_i) begin
        checks++;
        if (RecoverPCE_o !== e.rec) begin failures++; $display("FAIL alias[%0d] recoverPC got %h want %h", i, RecoverPCE_o, e.rec); end
      end
      i++;
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    int i = 0;
    do_reset();
    for (int k = 0; k < 5; k++)
      add(st(0, 1, 0, 32'h300, 0, 32'h000, 1, 32'h500, 32'h300),
          ex(0, 32'h304, 1, 32'h304, CW'(k > 3 ? 3 : k), CW'(k > 3 ? 3 : k)));
    idle(32'h300, ex(0, 32'h304, 0, '0, 3, 3));
    while (stims.size() > 0) begin
      drive(stims.pop_front(), exps.pop_front());
      e = sb.pop_front();
      checks += 5;
      if (PredTakenF_o !== e.pt) begin failures++; $display("FAIL sat[%0d] predTaken got %0b want %0b", i, PredTakenF_o, e.pt); end
      if (PredTargetF_o !== e.ptg) begin failures++; $display("FAIL sat[%0d] predTarget got %h want %h", i, PredTargetF_o, e.ptg); end
      if (MispredictE_o !== e.mis) begin failures++; $display("FAIL sat[%0d] mispredict got %0b want %0b", i, MispredictE_o, e.mis); end
      if (BranchCount_o !== e.bc) begin failures++; $display("FAIL sat[%0d] branchCount got %0d want %0d", i, BranchCount_o, e.bc); end
      if (MissCount_o !== e.mc) begin failures++; $display("FAIL sat[%0d] missCount got %0d want %0d", i, MissCount_o, e.mc); end
      if (UpdateE_i) begin
        checks++;
        if (RecoverPCE_o !== e.rec) begin failures++; $display("FAIL sat[%0d] recoverPC got %h want %h", i, RecoverPCE_o, e.rec); end
      end
      i++;
    end
  endtask

  task automatic test_jump();
    exp_t e;
    int i = 0;
    add(st(0, 1, 1, 32'h400, 1, 32'h800, 0, 32'h404, 32'h400), ex(0, 32'h404, 1, 32'h800, 3, 3));
    add(st(0, 1, 0, 32'h400, 0, 32'h800, 1, 32'h800, 32'h400), ex(1, 32'h800, 1, 32'h404, 3, 3));
    add(st(0, 1, 0, 32'h400, 0, 32'h800, 1, 32'h800, 32'h400), ex(1, 32'h800, 1, 32'h404, 3, 3));
    idle(32'h400, ex(1, 32'h800, 0, '0, 3, 3));
    while (stims.size() > 0) begin
      drive(stims.pop_front(), exps.pop_front());
      e = sb.pop_front();
      checks += 5;
      if (PredTakenF_o !== e.pt) begin failures++; $display("FAIL jump[%0d] predTaken got %0b want %0b", i, PredTakenF_o, e.pt); end
      if (PredTargetF_o !== e.ptg) begin failures++; $display("FAIL jump[%0d] predTarget got %h want %h", i, PredTargetF_o, e.ptg); end
      if (MispredictE_o !== e.mis) begin failures++; $display("FAIL jump[%0d] mispredict got %0b want %0b", i, MispredictE_o, e.mis); end
      if (BranchCount_o !== e.bc) begin failures++; $display("FAIL jump[%0d] branchCount got %0d want %0d", i, BranchCount_o, e.bc); end
      if (MissCount_o !== e.mc) begin failures++; $display("FAIL jump[%0d] missCount got %0d want %0d", i, MissCount_o, e.mc); end
      if (UpdateE_i) begin
        checks++;
        if (RecoverPCE_o !== e.rec) begin failures++; $display("FAIL jump[%0d] recoverPC got %h want %h", i, RecoverPCE_o, e.rec); end
      end
      i++;
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_allocate();
    test_counter_walk();
    test_alias();
    test_saturation();
    test_jump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised branch target buffer with 2-bit saturating direction counters for the 5-stage RV32I pipeline. The fetch stage queries it combinationally to choose the next PC. The execute stage updates it when a branch or jump resolves, and the block flags mispredictions with the recovery PC. Saturating performance counters track resolved branches and mispredictions.

Parameters:
PC_WIDTH, 32, PC/target width in bits
INDEX_WIDTH, 4, log2 of BTB entries (legal 1..10); index = PC[INDEX_WIDTH+1:2]
COUNT_WIDTH, 16, width of each performance counter
(derived) TAG_WIDTH = PC_WIDTH-INDEX_WIDTH-2; tag = PC[PC_WIDTH-1:INDEX_WIDTH+2]

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-high reset
PCF_i  in  PC_WIDTH  fetch-stage PC to look up
PredTakenF_o  out  1  predicted taken for PCF_i
PredTargetF_o  out  PC_WIDTH  predicted next PC for PCF_i
UpdateE_i  in  1  a branch/jump is resolved in execute this cycle
IsJumpE_i  in  1  resolved instruction is an unconditional jump
PCE_i  in  PC_WIDTH  PC of resolved instruction
TakenE_i  in  1  actual outcome
TargetE_i  in  PC_WIDTH  actual target address
PredTakenE_i  in  1  prediction made in fetch, piped to execute
PredTargetE_i  in  PC_WIDTH  predicted target, piped to execute
MispredictE_o  out  1  prediction was wrong; flush F/D, redirect
RecoverPCE_o  out  PC_WIDTH  correct next PC
BranchCount_o  out  COUNT_WIDTH  resolved updates seen
MissCount_o  out  COUNT_WIDTH  mispredictions seen

Behaviour:
- Storage per entry: valid, tag, target, ctr[1:0], jump bit. One clock domain; all state is updated only on the rising edge of clk_i.
- Reset (rst_i=1): all valid=0 and both perf counters=0. rst_i beats a simultaneous UpdateE_i, so no allocation or count happens in that cycle. Outputs after reset: PredTakenF_o=0, PredTargetF_o=PCF_i+4, MispredictE_o=0 unless UpdateE_i.
- Lookup (combinational, 0 latency):
  - hit = valid[idx] & tag match.
  - PredTakenF_o = hit & (jump | ctr[1]).
  - PredTargetF_o = PredTakenF_o ? target : PCF_i+4 (mod 2^PC_WIDTH).
- Lookup reads pre-edge state. An update to the same index in the same cycle is visible from the next cycle only; there is no bypass.
- Update (registered, on edge with UpdateE_i=1, rst_i=0):
  - Entry hit at PCE_i index/tag:
    - TakenE_i=1: ctr saturating-increments (max 11) and target<=TargetE_i.
    - TakenE_i=0: ctr saturating-decrements (min 00); target is unchanged.
    - IsJumpE_i=1: ctr<=11 and jump<=1.
  - Miss and TakenE_i=1: allocate by overwriting the index, regardless of its prior valid/tag. Set valid=1, tag, target=TargetE_i, jump=IsJumpE_i, ctr = IsJumpE_i ? 11 : 10.
  - Miss and TakenE_i=0: no change.
- Mispredict (combinational):
  - MispredictE_o = UpdateE_i & ((PredTakenE_i!=TakenE_i) | (TakenE_i & PredTargetE_i!=TargetE_i)).
  - RecoverPCE_o = TakenE_i ? TargetE_i : PCE_i+4. This is valid whenever UpdateE_i=1 and don't-care otherwise.
- Perf counters:
  - BranchCount_o +1 per update cycle; MissCount_o +1 per mispredict cycle.
  - Both saturate at all-ones and never wrap.
- PC bits [1:0] are ignored for indexing and tagging.

Test Plan:
- Reset, then PCF_i=0x100 -> PredTakenF_o=0, PredTargetF_o=0x104, BranchCount_o=0, MissCount_o=0.
- UpdateE_i with PCE_i=0x100, TakenE_i=1, TargetE_i=0x080, PredTakenE_i=0 -> same cycle MispredictE_o=1 and RecoverPCE_o=0x080. Next cycle PCF_i=0x100 gives PredTakenF_o=1, PredTargetF_o=0x080; BranchCount_o=1, MissCount_o=1.
- Counter walk from the entry above at ctr=10:
  - Not-taken update at 0x100 -> ctr=01, PredTakenF_o=0 (target output 0x104).
  - A further not-taken -> ctr=00; then a taken -> 01 (still not taken); another taken -> 10 (PredTakenF_o=1).
- Aliasing, INDEX_WIDTH=4, entry 0x100 valid: PCF_i=0x140 (same index 0, tag 5 vs 4) -> miss, target 0x144. Taken update at 0x140 to 0x200 -> 0x140 predicts 0x200 and 0x100 now misses.
- Same-cycle update/lookup: first taken allocation at 0x100 with PCF_i=0x100 -> PredTakenF_o=0 that cycle and 1 the next. With rst_i=1 asserted together with UpdateE_i -> no entry allocated, counters stay 0.
- COUNT_WIDTH=2, five consecutive mispredicting updates -> BranchCount_o=3, MissCount_o=3 (saturated). IsJumpE_i=1 allocation gives PredTakenF_o=1 even after a subsequent not-taken update on the same entry.
